// File: rtl/pwm_param_scheduler_pkg.sv
// Shared definitions for the PWM parameter scheduler: FSM encoding,
// target-select encoding, reset/clamp defaults and the clamp helper.
package pwm_param_scheduler_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  localparam logic SEL_DUTY = 1'b0;
  localparam logic SEL_FREQ = 1'b1;

  localparam int unsigned DUTY_RST_DEF = 50;
  localparam int unsigned FREQ_RST_DEF = 50;
  localparam int unsigned DUTY_MAX_DEF = 100;
  localparam int unsigned FREQ_MIN_DEF = 1;

  typedef struct packed {
    logic       clamped;
    logic [7:0] value;
  } clamp_t;

  // Duty writes are limited from above, frequency writes from below.
  function automatic clamp_t clamp_data(input logic       sel,
                                        input logic [7:0] data,
                                        input logic [7:0] duty_max,
                                        input logic [7:0] freq_min);
    clamp_t res;
    res.clamped = 1'b0;
    res.value   = data;
    if (sel == SEL_DUTY && data > duty_max) begin
      res.clamped = 1'b1;
      res.value   = duty_max;
    end else if (sel == SEL_FREQ && data < freq_min) begin
      res.clamped = 1'b1;
      res.value   = freq_min;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_param_scheduler_if.sv
// Requester/display-side bundle of the PWM parameter scheduler.
interface pwm_param_scheduler_if;
  logic       reqA;
  logic       reqB;
  logic       selA;
  logic       selB;
  logic [7:0] dataA;
  logic [7:0] dataB;
  logic       ackA;
  logic       ackB;
  logic       clampA;
  logic       clampB;
  logic [7:0] duty_cycle;
  logic [7:0] pwm_freq;
  logic       pending;

  // Requesters and display logic.
  modport master (
    output reqA, reqB, selA, selB, dataA, dataB,
    input  ackA, ackB, clampA, clampB, duty_cycle, pwm_freq, pending
  );

  // The scheduler itself.
  modport slave (
    input  reqA, reqB, selA, selB, dataA, dataB,
    output ackA, ackB, clampA, clampB, duty_cycle, pwm_freq, pending
  );
endinterface

// File: rtl/pwm_param_rr_arbiter.sv
// Two-way round-robin arbiter: A wins first after reset, then the loser of
// each grant holds priority; a lone requester always wins.
module pwm_param_rr_arbiter (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_grant_en,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  logic r_prio_b;

  // Grant decode from requests and the priority pointer.
  always_comb begin
    o_gnt_a = i_grant_en && i_req_a && (!i_req_b || !r_prio_b);
    o_gnt_b = i_grant_en && i_req_b && !o_gnt_a;
  end

  // Hand priority to the other requester after every grant.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_b <= 1'b0;
    end else if (o_gnt_a) begin
      r_prio_b <= 1'b1;
    end else if (o_gnt_b) begin
      r_prio_b <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_param_scheduler.sv
// Accepts duty/frequency writes from two requesters into shadow registers
// and commits them to the PWM/display outputs only at vertical-sync frame
// edges, so the datapath never changes mid-frame.
module pwm_param_scheduler
  import pwm_param_scheduler_pkg::*;
#(
  parameter int unsigned DUTY_RST = DUTY_RST_DEF,
  parameter int unsigned FREQ_RST = FREQ_RST_DEF,
  parameter int unsigned DUTY_MAX = DUTY_MAX_DEF,
  parameter int unsigned FREQ_MIN = FREQ_MIN_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 VD,
  pwm_param_scheduler_if.slave bus
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_win_b;
  logic       r_sel;
  logic [7:0] r_data;
  logic       r_clamp;
  logic [7:0] r_sh_duty;
  logic [7:0] r_sh_freq;
  logic [7:0] r_duty;
  logic [7:0] r_freq;
  logic       r_pending;
  logic       r_vd;

  logic       w_gnt_a;
  logic       w_gnt_b;
  logic       w_sel;
  logic [7:0] w_data;
  clamp_t     w_clamp;
  logic       w_write;
  logic       w_commit;
  logic [7:0] w_sh_duty_nxt;
  logic [7:0] w_sh_freq_nxt;
  logic [7:0] w_duty_nxt;
  logic [7:0] w_freq_nxt;
  logic       w_pending_nxt;

  pwm_param_rr_arbiter u_arb (
    .clk        (CLK),
    .rst_n      (RST_n),
    .i_req_a    (bus.reqA),
    .i_req_b    (bus.reqB),
    .i_grant_en (r_state == ST_IDLE),
    .o_gnt_a    (w_gnt_a),
    .o_gnt_b    (w_gnt_b)
  );

  // Winner's target/data, clamped before it is latched.
  always_comb begin
    w_sel   = w_gnt_b ? bus.selB  : bus.selA;
    w_data  = w_gnt_b ? bus.dataB : bus.dataA;
    w_clamp = clamp_data(w_sel, w_data, 8'(DUTY_MAX), 8'(FREQ_MIN));
  end

  // FSM next state and handshake outputs.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    bus.ackA    = 1'b0;
    bus.ackB    = 1'b0;
    bus.clampA  = 1'b0;
    bus.clampB  = 1'b0;
    case (r_state)
      ST_IDLE: if (w_gnt_a || w_gnt_b) w_state_nxt = ST_ACK;
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
        bus.ackA    = !r_win_b;
        bus.ackB    = r_win_b;
        bus.clampA  = !r_win_b && r_clamp;
        bus.clampB  = r_win_b && r_clamp;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Shadow write in ACK and frame commit; the commit takes the pre-write
  // shadow, so a write landing on a frame edge waits for the next frame.
  always_comb begin
    w_write       = (r_state == ST_ACK);
    w_commit      = VD && !r_vd && r_pending;
    w_sh_duty_nxt = (w_write && r_sel == SEL_DUTY) ? r_data : r_sh_duty;
    w_sh_freq_nxt = (w_write && r_sel == SEL_FREQ) ? r_data : r_sh_freq;
    w_duty_nxt    = w_commit ? r_sh_duty : r_duty;
    w_freq_nxt    = w_commit ? r_sh_freq : r_freq;
    w_pending_nxt = (w_sh_duty_nxt != w_duty_nxt) || (w_sh_freq_nxt != w_freq_nxt);
  end

  // FSM state register and latch of the granted request.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= ST_IDLE;
      r_win_b <= 1'b0;
      r_sel   <= SEL_DUTY;
      r_data  <= 8'd0;
      r_clamp <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && (w_gnt_a || w_gnt_b)) begin
        r_win_b <= w_gnt_b;
        r_sel   <= w_sel;
        r_data  <= w_clamp.value;
        r_clamp <= w_clamp.clamped;
      end
    end
  end

  // Shadow, committed values, pending flag and VD history.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_sh_duty <= 8'(DUTY_RST);
      r_sh_freq <= 8'(FREQ_RST);
      r_duty    <= 8'(DUTY_RST);
      r_freq    <= 8'(FREQ_RST);
      r_pending <= 1'b0;
      r_vd      <= 1'b0;
    end else begin
      r_sh_duty <= w_sh_duty_nxt;
      r_sh_freq <= w_sh_freq_nxt;
      r_duty    <= w_duty_nxt;
      r_freq    <= w_freq_nxt;
      r_pending <= w_pending_nxt;
      r_vd      <= VD;
    end
  end

  assign bus.duty_cycle = r_duty;
  assign bus.pwm_freq   = r_freq;
  assign bus.pending    = r_pending;

endmodule
